// File: rtl/mm_accel_pkg.sv
// Shared definitions for the matrix-multiply accelerator controller.
// Contents:
//   mm_state_e  : controller FSM states (RD_C is used only when MM_ACCUM_EN is defined)
//   MM_OPCODE   : custom opcode that the decoder maps onto operation_en
//   defaults    : matrix dimension and the A/B/C byte base addresses
//   idx_width() : width of an i/j/k index register for a given dimension
//   elem_addr() : byte address of element [row][col] of a row-major word matrix
package mm_accel_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_C = 3'd3,
    DONE = 3'd4,
    RD_C = 3'd5
  } mm_state_e;

  localparam logic [6:0]  MM_OPCODE          = 7'b1111111;
  localparam int          MM_N_DEFAULT       = 4;
  localparam logic [31:0] MM_A_BASE_DEFAULT  = 32'h0000_0100;
  localparam logic [31:0] MM_B_BASE_DEFAULT  = 32'h0000_0200;
  localparam logic [31:0] MM_C_BASE_DEFAULT  = 32'h0000_0300;

  // Index registers hold 0..n-1; a single bit is kept even for degenerate n.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MM_IDX_W = idx_width(MM_N_DEFAULT);

  // Row-major matrix of 4-byte words starting at base.
  function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                            input logic [31:0] row,
                                            input logic [31:0] col,
                                            input logic [31:0] n);
    return base + ((row * n + col) << 2);
  endfunction

endpackage

// File: rtl/mm_accel_ctrl_mac.sv
// 32x32 multiply-accumulate register used by mm_accel_ctrl.
// Ports:
//   clk, reset : clock and asynchronous active-low reset (acc clears to 0)
//   clr        : when set with en, the old accumulator value is discarded
//   en         : update acc on this clock edge
//   a, b       : operands; only the low 32 bits of the product are kept
//   acc        : accumulator value (modulo 2^32)
module mm_mac (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] acc
);

  logic [31:0] prod_s;
  logic [31:0] acc_r;

  // Low word of the product is the same for signed and unsigned operands.
  assign prod_s = a * b;
  assign acc    = acc_r;

  // Accumulator register: clear-and-load or add on enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= 32'd0;
    end else if (en) begin
      acc_r <= (clr ? 32'd0 : acc_r) + prod_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/mm_accel_ctrl.sv
// Matrix-multiply accelerator controller: answers the custom MM instruction.
// While busy it owns the data-memory port, stalls the core, computes
// C = A x B over N x N 32-bit word matrices at fixed byte addresses and
// finishes with a one-cycle done pulse.
// Build option: define MM_ACCUM_EN to compute C = C + A x B instead; this adds
// an RD_C state that loads the old C element before each dot product.
// Ports:
//   clk          : clock, all state on the rising edge
//   reset        : asynchronous active-low reset
//   operation_en : decoder strobe, high while the MM instruction is in decode
//   drdata       : dmem read data (combinational read of daddr)
//   daddr        : dmem byte address, word aligned
//   dwdata       : dmem write data
//   dwe          : dmem byte write enables
//   busy         : registered, high whenever the FSM is not IDLE (dmem mux select)
//   stall        : combinational, holds PC and decode
//   done         : one-cycle completion pulse
module mm_accel_ctrl
  import mm_accel_pkg::*;
#(
  parameter int          N      = MM_N_DEFAULT,
  parameter logic [31:0] A_BASE = MM_A_BASE_DEFAULT,
  parameter logic [31:0] B_BASE = MM_B_BASE_DEFAULT,
  parameter logic [31:0] C_BASE = MM_C_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        operation_en,
  input  logic [31:0] drdata,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam int             IW       = idx_width(N);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0]  ZERO_IDX = {IW{1'b0}};
  localparam logic [IW-1:0]  ONE_IDX  = IW'(1);
  localparam logic [31:0]    N_W      = 32'(N);

`ifdef MM_ACCUM_EN
  localparam mm_state_e ELEM_START = RD_C;
`else
  localparam mm_state_e ELEM_START = RD_A;
`endif

  mm_state_e     state_r;
  mm_state_e     state_next;
  logic [IW-1:0] i_r;
  logic [IW-1:0] j_r;
  logic [IW-1:0] k_r;
  logic [31:0]   a_reg_r;
  logic          busy_r;
  logic          done_r;

  logic          mac_clr_s;
  logic          mac_en_s;
  logic [31:0]   mac_a_s;
  logic [31:0]   mac_b_s;
  logic [31:0]   acc_s;

  assign busy = busy_r;
  assign done = done_r;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; operation_en only matters in IDLE.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (operation_en) begin
          state_next = ELEM_START;
        end else begin
          state_next = IDLE;
        end
      end
`ifdef MM_ACCUM_EN
      RD_C: state_next = RD_A;
`endif
      RD_A: state_next = RD_B;
      RD_B: begin
        if (k_r == LAST_IDX) begin
          state_next = WR_C;
        end else begin
          state_next = RD_A;
        end
      end
      WR_C: begin
        if ((i_r == LAST_IDX) && (j_r == LAST_IDX)) begin
          state_next = DONE;
        end else begin
          state_next = ELEM_START;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Loop indices: k steps per product, j per element, i per row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_r <= ZERO_IDX;
      j_r <= ZERO_IDX;
      k_r <= ZERO_IDX;
    end else begin
      case (state_r)
        IDLE: begin
          if (operation_en) begin
            i_r <= ZERO_IDX;
            j_r <= ZERO_IDX;
            k_r <= ZERO_IDX;
          end
        end
        RD_B: begin
          k_r <= (k_r == LAST_IDX) ? ZERO_IDX : (k_r + ONE_IDX);
        end
        WR_C: begin
          if (j_r == LAST_IDX) begin
            j_r <= ZERO_IDX;
            i_r <= (i_r == LAST_IDX) ? ZERO_IDX : (i_r + ONE_IDX);
          end else begin
            j_r <= j_r + ONE_IDX;
          end
        end
        default: begin
          k_r <= k_r;
        end
      endcase
    end
  end

  // A operand latch, captured while A[i][k] is on the read bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg_r <= 32'd0;
    end else if (state_r == RD_A) begin
      a_reg_r <= drdata;
    end else begin
      a_reg_r <= a_reg_r;
    end
  end

  // busy/done registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next != IDLE);
      done_r <= (state_next == DONE);
    end
  end

  // MAC control. RD_C loads the old C element as drdata*1 with a clear.
  always_comb begin
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    mac_a_s   = a_reg_r;
    mac_b_s   = drdata;
    case (state_r)
      RD_B: begin
        mac_en_s = 1'b1;
`ifdef MM_ACCUM_EN
        mac_clr_s = 1'b0;
`else
        mac_clr_s = (k_r == ZERO_IDX);
`endif
      end
`ifdef MM_ACCUM_EN
      RD_C: begin
        mac_en_s  = 1'b1;
        mac_clr_s = 1'b1;
        mac_a_s   = drdata;
        mac_b_s   = 32'd1;
      end
`endif
      default: begin
        mac_en_s = 1'b0;
      end
    endcase
  end

  mm_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr_s),
    .en    (mac_en_s),
    .a     (mac_a_s),
    .b     (mac_b_s),
    .acc   (acc_s)
  );

  // Memory port decode; idle states drive zeros.
  always_comb begin
    daddr  = 32'd0;
    dwdata = 32'd0;
    dwe    = 4'h0;
    case (state_r)
      RD_A: daddr = elem_addr(A_BASE, 32'(i_r), 32'(k_r), N_W);
      RD_B: daddr = elem_addr(B_BASE, 32'(k_r), 32'(j_r), N_W);
      WR_C: begin
        daddr  = elem_addr(C_BASE, 32'(i_r), 32'(j_r), N_W);
        dwdata = acc_s;
        dwe    = 4'hF;
      end
`ifdef MM_ACCUM_EN
      RD_C: daddr = elem_addr(C_BASE, 32'(i_r), 32'(j_r), N_W);
`endif
      default: begin
        dwe = 4'h0;
      end
    endcase
  end

  // Stall covers the accepting IDLE cycle and every memory state, not DONE.
  always_comb begin
    stall = 1'b0;
    case (state_r)
      IDLE:             stall = operation_en;
      RD_A, RD_B, WR_C: stall = 1'b1;
`ifdef MM_ACCUM_EN
      RD_C:             stall = 1'b1;
`endif
      default:          stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mm_accel_ctrl.sv
module tb_mm_accel_ctrl;
  import mm_accel_pkg::*;

`ifdef MM_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif
  localparam int STALL_EXP = ACCUM ? 161 : 145;
  localparam int DONE_EXP  = STALL_EXP + 1;
  localparam int A_W = 64;
  localparam int B_W = 128;
  localparam int C_W = 192;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        operation_en = 1'b0;
  logic [31:0] drdata;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic        busy;
  logic        stall;
  logic        done;

  logic [31:0] mem [0:255];
  logic [63:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  assign drdata = mem[daddr[9:2]];

  mm_accel_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .operation_en (operation_en),
    .drdata       (drdata),
    .daddr        (daddr),
    .dwdata       (dwdata),
    .dwe          (dwe),
    .busy         (busy),
    .stall        (stall),
    .done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every DUT write pops one expected {addr,data}.
  task automatic monitor_loop();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (dwe != 4'h0) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", daddr, dwdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", daddr, e[63:32]);
          check("wr_data", dwdata, e[31:0]);
          check("wr_dwe", {28'd0, dwe}, 32'h0000_000F);
        end
        if (dwe == 4'hF) mem[daddr[9:2]] = dwdata;
      end
    end
  endtask

  task automatic clear_mats();
    for (int x = 64; x < 256; x++) mem[x] = 32'd0;
  endtask

  // Expected C element: old contents added only in the accumulate build.
  task automatic push_c(input int idx, input logic [31:0] v);
    logic [31:0] base;
    base = ACCUM ? mem[C_W + idx] : 32'd0;
    exp_q.push_back({MM_C_BASE_DEFAULT + 32'(idx * 4), base + v});
  endtask

  task automatic load_identity_a();
    for (int r = 0; r < 4; r++) mem[A_W + r * 4 + r] = 32'd1;
  endtask

  task automatic run_op(output int stall_cnt, output int done_cyc);
    int cyc;
    cyc = 0; stall_cnt = 0; done_cyc = 0;
    @(posedge clk); #1 operation_en = 1'b1;
    while (cyc < 600 && done_cyc == 0) begin
      @(negedge clk);
      cyc++;
      if (stall) stall_cnt++;
      if (done) done_cyc = cyc;
      @(posedge clk); #1 operation_en = 1'b0;
    end
  endtask

  int sc, dc, nwr, ndone, fd, sd, cyc;

  initial begin
    for (int x = 0; x < 256; x++) mem[x] = 32'd0;
    fork
      monitor_loop();
    join_none

    // Reset state
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dwe", {28'd0, dwe}, 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dwdata", dwdata, 32'd0);
    check("rst_stall_lo", {31'd0, stall}, 32'd0);
    operation_en = 1'b1; #1;
    check("rst_stall_follows_en", {31'd0, stall}, 32'd1);
    operation_en = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_write_count", 32'(wr_count), 32'd0);

    // Identity x B -> C = B
    clear_mats();
    load_identity_a();
    for (int x = 0; x < 16; x++) mem[B_W + x] = 32'(x);
    for (int x = 0; x < 16; x++) push_c(x, 32'(x));
    run_op(sc, dc);
    check("ident_stall_cycles", 32'(sc), 32'(STALL_EXP));
    check("ident_done_cycle", 32'(dc), 32'(DONE_EXP));
    check("ident_queue_empty", 32'(exp_q.size()), 32'd0);

    // All 2 x all 3 -> 24, sixteen writes in address order
    clear_mats();
    for (int x = 0; x < 16; x++) begin mem[A_W + x] = 32'd2; mem[B_W + x] = 32'd3; end
    for (int x = 0; x < 16; x++) push_c(x, 32'd24);
    nwr = wr_count;
    run_op(sc, dc);
    check("const_write_count", 32'(wr_count - nwr), 32'd16);
    check("const_queue_empty", 32'(exp_q.size()), 32'd0);

    // 0x10000 * 0x10000 wraps to 0
    clear_mats();
    mem[A_W] = 32'h0001_0000; mem[B_W] = 32'h0001_0000;
    mem[C_W] = 32'h1234_5678;
    if (ACCUM) mem[C_W] = 32'd0;
    for (int x = 0; x < 16; x++) push_c(x, 32'd0);
    run_op(sc, dc);
    check("wrap_c00", mem[C_W], 32'd0);

    // 0xFFFFFFFF * 2 -> 0xFFFFFFFE
    clear_mats();
    mem[A_W] = 32'hFFFF_FFFF; mem[B_W] = 32'd2;
    push_c(0, 32'hFFFF_FFFE);
    for (int x = 1; x < 16; x++) push_c(x, 32'd0);
    run_op(sc, dc);
    check("neg_c00", mem[C_W], 32'hFFFF_FFFE);

    // Reset at cycle 40 of an operation
    clear_mats();
    load_identity_a();
    for (int x = 0; x < 16; x++) mem[B_W + x] = 32'(x + 100);
    for (int x = 0; x < 16; x++) mem[C_W + x] = 32'hDEAD_0000 | 32'(x);
    nwr = ACCUM ? 3 : 4;
    for (int x = 0; x < nwr; x++) push_c(x, 32'(x + 100));
    @(posedge clk); #1 operation_en = 1'b1;
    for (int c = 1; c < 40; c++) begin
      @(posedge clk); #1 operation_en = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_dwe", {28'd0, dwe}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int x = nwr; x < 16; x++) check("abort_c_untouched", mem[C_W + x], 32'hDEAD_0000 | 32'(x));
    for (int x = 0; x < 16; x++) push_c(x, 32'(x + 100));
    run_op(sc, dc);
    check("rerun_stall_cycles", 32'(sc), 32'(STALL_EXP));
    check("rerun_done_cycle", 32'(dc), 32'(DONE_EXP));

    // operation_en held through DONE and two more cycles -> two operations
    clear_mats();
    for (int x = 0; x < 16; x++) begin mem[A_W + x] = 32'd2; mem[B_W + x] = 32'd3; end
    for (int x = 0; x < 16; x++) push_c(x, 32'd24);
    for (int x = 0; x < 16; x++) push_c(x, ACCUM ? 32'd48 : 32'd24);
    cyc = 0; sc = 0; ndone = 0; fd = 0; sd = 0;
    @(posedge clk); #1 operation_en = 1'b1;
    while (cyc < 2 * DONE_EXP + 10) begin
      @(negedge clk);
      cyc++;
      if (stall) sc++;
      if (done) begin
        ndone++;
        if (fd == 0) fd = cyc;
        else if (sd == 0) sd = cyc;
      end
      if (fd != 0 && cyc == fd + 1) begin
        check("b2b_gap_busy", {31'd0, busy}, 32'd0);
        check("b2b_gap_stall", {31'd0, stall}, 32'd1);
      end
      @(posedge clk); #1 operation_en = (fd == 0) || (cyc + 1 <= fd + 2);
    end
    check("b2b_done_pulses", 32'(ndone), 32'd2);
    check("b2b_first_done", 32'(fd), 32'(DONE_EXP));
    check("b2b_second_done", 32'(sd), 32'(2 * DONE_EXP));
    check("b2b_stall_cycles", 32'(sc), 32'(2 * STALL_EXP));
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    check("b2b_end_busy", {31'd0, busy}, 32'd0);

`ifdef MM_ACCUM_EN
    // C preloaded with 1, A = B = identity -> C = identity + 1
    clear_mats();
    load_identity_a();
    for (int r = 0; r < 4; r++) mem[B_W + r * 4 + r] = 32'd1;
    for (int x = 0; x < 16; x++) mem[C_W + x] = 32'd1;
    for (int x = 0; x < 16; x++) push_c(x, ((x % 5) == 0) ? 32'd1 : 32'd0);
    run_op(sc, dc);
    check("accum_stall_cycles", 32'(sc), 32'd161);
    check("accum_c00", mem[C_W], 32'd2);
    check("accum_c01", mem[C_W + 1], 32'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
